// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the stack CPU control sequencer.
// Instruction classes, SYS sub-ops, jump conditions and SP control words live here.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'b00,
    ST_EXEC  = 2'b01,
    ST_EXEC2 = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    CLS_LIT = 2'b00,
    CLS_ALU = 2'b01,
    CLS_JMP = 2'b10,
    CLS_SYS = 2'b11
  } class_e;

  localparam logic [3:0] SYS_NOP  = 4'd0;
  localparam logic [3:0] SYS_PUSH = 4'd1;
  localparam logic [3:0] SYS_POP  = 4'd2;
  localparam logic [3:0] SYS_HALT = 4'd3;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_Z      = 3'b001;
  localparam logic [2:0] COND_NZ     = 3'b010;
  localparam logic [2:0] COND_S      = 3'b011;
  localparam logic [2:0] COND_NS     = 3'b100;
  localparam logic [2:0] COND_C      = 3'b101;
  localparam logic [2:0] COND_NC     = 3'b110;
  localparam logic [2:0] COND_NEVER  = 3'b111;

  // {select, inc, dec}
  localparam logic [2:0] SP_CTRL_IDLE = 3'b000;
  localparam logic [2:0] SP_CTRL_INC  = 3'b110;
  localparam logic [2:0] SP_CTRL_DEC  = 3'b101;

  typedef struct packed {
    logic       ip_en;
    logic       ip_sel;
    logic       stk_addr_sel;
    logic       stk_w;
    logic       stk_s;
    logic [2:0] sp_ctrl;
    logic       r_w;
    logic       r_s;
    logic       t_w;
    logic       t_in;
    logic       carry_w;
    logic       instr_type;
    logic [4:0] alu_op;
    logic [1:0] jsel;
  } ctrl_t;

  function automatic logic is_two_cycle(input logic [3:0] sub_op);
    return (sub_op == SYS_PUSH) || (sub_op == SYS_POP);
  endfunction

endpackage

// File: rtl/stack_cpu_sequencer_if.sv
// Sequencer <-> ROM/datapath signal bundle.
// master is the sequencer side, slave is the datapath/ROM side.
interface stack_cpu_sequencer_if #(
  parameter int DW = 16,
  parameter int IW = 18
);

  logic [IW-1:0] i_instruction;
  logic [DW-1:0] i_cond_val;
  logic          i_carry;
  logic          i_stall;

  logic          o_ip_en;
  logic          o_ip_sel;
  logic          o_stk_addr_sel;
  logic          o_stk_w;
  logic          o_stk_s;
  logic [2:0]    o_sp_ctrl;
  logic          o_r_w;
  logic          o_r_s;
  logic          o_t_w;
  logic          o_t_in;
  logic          o_carry_w;
  logic          o_instr_type;
  logic [4:0]    o_alu_op;
  logic [1:0]    o_jsel;
  logic          o_halted;

  modport master (
    input  i_instruction, i_cond_val, i_carry, i_stall,
    output o_ip_en, o_ip_sel, o_stk_addr_sel, o_stk_w, o_stk_s, o_sp_ctrl,
           o_r_w, o_r_s, o_t_w, o_t_in, o_carry_w, o_instr_type, o_alu_op,
           o_jsel, o_halted
  );

  modport slave (
    output i_instruction, i_cond_val, i_carry, i_stall,
    input  o_ip_en, o_ip_sel, o_stk_addr_sel, o_stk_w, o_stk_s, o_sp_ctrl,
           o_r_w, o_r_s, o_t_w, o_t_in, o_carry_w, o_instr_type, o_alu_op,
           o_jsel, o_halted
  );

endinterface

// File: rtl/cond_eval.sv
// Jump condition evaluator: derives Z/S/C from the flag-mux value and carry,
// then matches them against the 3-bit condition code.
module cond_eval
  import cpu_ctrl_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] cond_val,
  input  logic          carry,
  input  logic [2:0]    cond,
  output logic          taken
);

  logic zero;
  logic sign;

  assign zero = (cond_val == '0);
  assign sign = cond_val[DW-1];

  always_comb begin
    // NOTE: default assignment first so every path drives taken; no latch.
    taken = 1'b0;
    unique case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_Z:      taken = zero;
      COND_NZ:     taken = !zero;
      COND_S:      taken = sign;
      COND_NS:     taken = !sign;
      COND_C:      taken = carry;
      COND_NC:     taken = !carry;
      COND_NEVER:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/stack_cpu_sequencer.sv
// Multi-cycle control sequencer for the 16-bit stack CPU: decodes the ROM word
// and drives every datapath strobe from a RST/EXEC/EXEC2/HALT state machine.
module stack_cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int IW = 18
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  stack_cpu_sequencer_if.master bus
);

  state_e state_q, state_d;
  logic   rel_q, rel_d;

  class_e     cls;
  logic [3:0] sub_op;
  logic [2:0] cond;
  logic       taken;
  logic       stall;
  logic       unused_payload;
  ctrl_t      dec;
  ctrl_t      ctrl;

  assign cls            = class_e'(bus.i_instruction[IW-1:IW-2]);
  assign sub_op         = bus.i_instruction[15:12];
  assign cond           = bus.i_instruction[15:13];
  assign stall          = bus.i_stall;
  assign unused_payload = ^bus.i_instruction[10:6];

  cond_eval #(.DW(DW)) u_cond_eval (
    .cond_val (bus.i_cond_val),
    .carry    (bus.i_carry),
    .cond     (cond),
    .taken    (taken)
  );

  // rel_q rises on the first edge after reset release; RST leaves on the next one.
  always_comb begin
    rel_d   = 1'b1;
    state_d = state_q;
    unique case (state_q)
      ST_RST: begin
        if (rel_q) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (!stall && cls == CLS_SYS) begin
          if (is_two_cycle(sub_op))    state_d = ST_EXEC2;
          else if (sub_op == SYS_HALT) state_d = ST_HALT;
        end
      end
      ST_EXEC2: begin
        if (!stall) state_d = ST_EXEC;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_RST;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
    end
  end

  // Decode: RST and HALT leave everything at zero.
  always_comb begin
    dec = '0;
    if (state_q == ST_EXEC || state_q == ST_EXEC2) dec.instr_type = (cls != CLS_ALU);

    unique case (state_q)
      ST_EXEC: begin
        unique case (cls)
          CLS_LIT: begin
            dec.t_in  = 1'b1;
            dec.t_w   = 1'b1;
            dec.ip_en = 1'b1;
          end
          CLS_ALU: begin
            dec.alu_op  = bus.i_instruction[4:0];
            dec.carry_w = bus.i_instruction[5];
            dec.r_w     = 1'b1;
            dec.ip_en   = 1'b1;
          end
          CLS_JMP: begin
            dec.jsel   = bus.i_instruction[12:11];
            dec.ip_sel = taken;
            dec.ip_en  = 1'b1;
          end
          CLS_SYS: begin
            case (sub_op)
              SYS_PUSH: dec.sp_ctrl = SP_CTRL_INC;
              SYS_POP: begin
                dec.stk_s = 1'b1;
                dec.t_in  = 1'b0;
                dec.t_w   = 1'b1;
              end
              SYS_HALT: dec.ip_en = 1'b0;
              default:  dec.ip_en = 1'b1;
            endcase
          end
        endcase
      end
      ST_EXEC2: begin
        // The ROM word is still the PUSH/POP since IP has not advanced yet.
        if (cls == CLS_SYS && sub_op == SYS_PUSH) begin
          dec.r_s   = 1'b1;
          dec.stk_w = 1'b1;
          dec.ip_en = 1'b1;
        end else if (cls == CLS_SYS && sub_op == SYS_POP) begin
          dec.sp_ctrl = SP_CTRL_DEC;
          dec.ip_en   = 1'b1;
        end else begin
          dec.ip_en = 1'b1;
        end
      end
      default: dec = '0;
    endcase
  end

  // Stall suppresses every write/step strobe but leaves the mux selects alone.
  always_comb begin
    ctrl = dec;
    if (stall) begin
      ctrl.ip_en        = 1'b0;
      ctrl.stk_w        = 1'b0;
      ctrl.r_w          = 1'b0;
      ctrl.t_w          = 1'b0;
      ctrl.carry_w      = 1'b0;
      ctrl.sp_ctrl[1:0] = 2'b00;
    end
  end

  assign bus.o_ip_en        = ctrl.ip_en;
  assign bus.o_ip_sel       = ctrl.ip_sel;
  assign bus.o_stk_addr_sel = ctrl.stk_addr_sel;
  assign bus.o_stk_w        = ctrl.stk_w;
  assign bus.o_stk_s        = ctrl.stk_s;
  assign bus.o_sp_ctrl      = ctrl.sp_ctrl;
  assign bus.o_r_w          = ctrl.r_w;
  assign bus.o_r_s          = ctrl.r_s;
  assign bus.o_t_w          = ctrl.t_w;
  assign bus.o_t_in         = ctrl.t_in;
  assign bus.o_carry_w      = ctrl.carry_w;
  assign bus.o_instr_type   = ctrl.instr_type;
  assign bus.o_alu_op       = ctrl.alu_op;
  assign bus.o_jsel         = ctrl.jsel;
  assign bus.o_halted       = (state_q == ST_HALT);

endmodule

// File: tb/tb_stack_cpu_sequencer.sv
// Directed self-checking bench for stack_cpu_sequencer; inputs change on the
// falling edge and outputs are checked 1 ns later.
module tb_stack_cpu_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  stack_cpu_sequencer_if #(.DW(16), .IW(18)) bus ();

  stack_cpu_sequencer #(.DW(16), .IW(18)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // {ip_en, ip_sel, stk_addr_sel, stk_w, stk_s, sp_ctrl, r_w, r_s, t_w, t_in,
  //  carry_w, instr_type, alu_op, jsel, halted}
  function automatic logic [21:0] outs();
    return {bus.o_ip_en, bus.o_ip_sel, bus.o_stk_addr_sel, bus.o_stk_w,
            bus.o_stk_s, bus.o_sp_ctrl, bus.o_r_w, bus.o_r_s, bus.o_t_w,
            bus.o_t_in, bus.o_carry_w, bus.o_instr_type, bus.o_alu_op,
            bus.o_jsel, bus.o_halted};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [17:0] instr, input logic stall);
    @(negedge clk);
    bus.i_instruction = instr;
    bus.i_stall       = stall;
    #1;
  endtask

  localparam logic [17:0] I_LIT   = 18'h01234;
  localparam logic [17:0] I_ALU   = 18'h10029;
  localparam logic [17:0] I_JZ    = 18'h23000;
  localparam logic [17:0] I_JNZ   = 18'h24000;
  localparam logic [17:0] I_JS    = 18'h26000;
  localparam logic [17:0] I_JC    = 18'h2A000;
  localparam logic [17:0] I_JNEV  = 18'h2E000;
  localparam logic [17:0] I_NOP   = 18'h30000;
  localparam logic [17:0] I_PUSH  = 18'h31000;
  localparam logic [17:0] I_POP   = 18'h32000;
  localparam logic [17:0] I_HALT  = 18'h33000;
  localparam logic [17:0] I_SYS9  = 18'h39000;

  initial begin
    logic [17:0] halt_vec [5];
    halt_vec[0] = I_LIT;
    halt_vec[1] = I_ALU;
    halt_vec[2] = 18'h20000;
    halt_vec[3] = I_PUSH;
    halt_vec[4] = I_NOP;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.i_instruction = I_LIT;
    bus.i_cond_val    = 16'h0000;
    bus.i_carry       = 1'b0;
    bus.i_stall       = 1'b0;

    // Reset held, then release and one RST cycle
    cyc(I_LIT, 1'b0);
    check("rst_held_outs", 32'(outs()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_outs", 32'(outs()), 32'h0);
    cyc(I_LIT, 1'b0);
    check("rst_cycle_outs", 32'(outs()), 32'h0);

    // LIT
    cyc(I_LIT, 1'b0);
    check("lit_t_in", 32'(bus.o_t_in), 32'h1);
    check("lit_t_w", 32'(bus.o_t_w), 32'h1);
    check("lit_ip_en", 32'(bus.o_ip_en), 32'h1);
    check("lit_ip_sel", 32'(bus.o_ip_sel), 32'h0);

    // ALU op 01001 with carry write
    cyc(I_ALU, 1'b0);
    check("alu_op", 32'(bus.o_alu_op), 32'h09);
    check("alu_carry_w", 32'(bus.o_carry_w), 32'h1);
    check("alu_r_w", 32'(bus.o_r_w), 32'h1);
    check("alu_ip_en", 32'(bus.o_ip_en), 32'h1);
    check("alu_instr_type", 32'(bus.o_instr_type), 32'h0);

    // Stalled LIT: strobes masked, mux select kept, state holds
    cyc(I_LIT, 1'b1);
    check("stall_lit_t_w", 32'(bus.o_t_w), 32'h0);
    check("stall_lit_t_in", 32'(bus.o_t_in), 32'h1);
    check("stall_lit_ip_en", 32'(bus.o_ip_en), 32'h0);

    // Jumps
    cyc(I_JZ, 1'b0);
    bus.i_cond_val = 16'h0000;
    #1;
    check("jz_zero_ip_sel", 32'(bus.o_ip_sel), 32'h1);
    check("jz_jsel", 32'(bus.o_jsel), 32'h2);
    check("jz_ip_en", 32'(bus.o_ip_en), 32'h1);
    cyc(I_JZ, 1'b0);
    bus.i_cond_val = 16'h0001;
    #1;
    check("jz_nonzero_ip_sel", 32'(bus.o_ip_sel), 32'h0);
    cyc(I_JNEV, 1'b0);
    bus.i_cond_val = 16'h0000;
    bus.i_carry    = 1'b1;
    #1;
    check("jnever_ip_sel", 32'(bus.o_ip_sel), 32'h0);
    cyc(I_JC, 1'b0);
    bus.i_carry = 1'b1;
    #1;
    check("jc_carry1_ip_sel", 32'(bus.o_ip_sel), 32'h1);
    cyc(I_JC, 1'b0);
    bus.i_carry = 1'b0;
    #1;
    check("jc_carry0_ip_sel", 32'(bus.o_ip_sel), 32'h0);
    cyc(I_JS, 1'b0);
    bus.i_cond_val = 16'h8000;
    #1;
    check("js_neg_ip_sel", 32'(bus.o_ip_sel), 32'h1);
    cyc(I_JNZ, 1'b0);
    bus.i_cond_val = 16'h0005;
    #1;
    check("jnz_ip_sel", 32'(bus.o_ip_sel), 32'h1);

    // Unassigned SYS sub-op behaves as NOP
    cyc(I_SYS9, 1'b0);
    check("sys9_ip_en", 32'(bus.o_ip_en), 32'h1);
    check("sys9_sp_ctrl", 32'(bus.o_sp_ctrl), 32'h0);

    // PUSH with a 3-cycle stall in EXEC2
    cyc(I_PUSH, 1'b0);
    check("push1_sp_ctrl", 32'(bus.o_sp_ctrl), 32'h6);
    check("push1_ip_en", 32'(bus.o_ip_en), 32'h0);
    check("push1_stk_w", 32'(bus.o_stk_w), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(I_PUSH, 1'b1);
      check($sformatf("push_stall%0d_stk_w", i), 32'(bus.o_stk_w), 32'h0);
      check($sformatf("push_stall%0d_ip_en", i), 32'(bus.o_ip_en), 32'h0);
      check($sformatf("push_stall%0d_r_s", i), 32'(bus.o_r_s), 32'h1);
    end
    cyc(I_PUSH, 1'b0);
    check("push2_stk_w", 32'(bus.o_stk_w), 32'h1);
    check("push2_r_s", 32'(bus.o_r_s), 32'h1);
    check("push2_ip_en", 32'(bus.o_ip_en), 32'h1);
    check("push2_sp_ctrl", 32'(bus.o_sp_ctrl), 32'h0);
    cyc(I_NOP, 1'b0);
    check("after_push_stk_w", 32'(bus.o_stk_w), 32'h0);
    check("after_push_ip_en", 32'(bus.o_ip_en), 32'h1);

    // POP
    cyc(I_POP, 1'b0);
    check("pop1_stk_s", 32'(bus.o_stk_s), 32'h1);
    check("pop1_t_w", 32'(bus.o_t_w), 32'h1);
    check("pop1_t_in", 32'(bus.o_t_in), 32'h0);
    check("pop1_ip_en", 32'(bus.o_ip_en), 32'h0);
    cyc(I_POP, 1'b0);
    check("pop2_sp_ctrl", 32'(bus.o_sp_ctrl), 32'h5);
    check("pop2_ip_en", 32'(bus.o_ip_en), 32'h1);
    check("pop2_t_w", 32'(bus.o_t_w), 32'h0);

    // Reset asserted during POP cycle 1
    cyc(I_POP, 1'b0);
    check("pop_rst_pre_stk_s", 32'(bus.o_stk_s), 32'h1);
    rst_n = 1'b0;
    #1;
    check("pop_rst_outs", 32'(outs()), 32'h0);

    // Release, one RST cycle, then HALT
    cyc(I_HALT, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst2_release_outs", 32'(outs()), 32'h0);
    cyc(I_HALT, 1'b0);
    check("rst2_cycle_outs", 32'(outs()), 32'h0);
    cyc(I_HALT, 1'b0);
    check("halt_exec_ip_en", 32'(bus.o_ip_en), 32'h0);
    check("halt_exec_halted", 32'(bus.o_halted), 32'h0);
    for (int i = 0; i < 10; i++) begin
      cyc(halt_vec[i % 5], 1'(i % 2));
      check($sformatf("halt%0d_outs", i), 32'(outs()), 32'h1);
    end
    rst_n = 1'b0;
    #1;
    check("halt_rst_outs", 32'(outs()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
